// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: debounced button operands, iterative decimal split of their sum, multiplexed 4-digit display scan
module seg_scan_ctrl #(
  parameter int DEB_CYCLES = 250000,
  parameter int SCAN_DIV   = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] btn,
  output logic [3:0] dig_val,
  output logic [3:0] dig_an,
  output logic       busy,
  output logic       upd
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {IDLE, LOAD, DIV, COMMIT} state_t;
  state_t state, nxt;
  logic [7:0] s1, s, cand, committed;
  logic [DW-1:0] deb_cnt;
  logic [3:0] op_a, op_b, q, disp_a, disp_b, tens, ones;
  logic [4:0] rem;
  logic [SW-1:0] tick;
  logic [1:0] idx;
  logic stable, trig, wrap;
  // synchronize inverted buttons and require DEB_CYCLES of stability before a value is usable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s <= '0;
      cand <= '0;
      deb_cnt <= '0;
    end else begin
      s1 <= ~btn;
      s <= s1;
      if (s != cand) begin
        cand <= s;
        deb_cnt <= '0;
      end else if (deb_cnt != DW'(DEB_CYCLES)) deb_cnt <= deb_cnt + 1'b1;
    end
  end
  // conversion state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  // next state and status; the trigger is level based so a change seen while busy fires on the next IDLE cycle
  always_comb begin
    stable = deb_cnt == DW'(DEB_CYCLES);
    trig = state == IDLE && stable && cand != committed;
    busy = state != IDLE;
    upd = state == COMMIT;
    nxt = state;
    case (state)
      IDLE:    nxt = trig ? LOAD : IDLE;
      LOAD:    nxt = DIV;
      DIV:     nxt = rem >= 5'd10 ? DIV : COMMIT;
      default: nxt = IDLE;
    endcase
  end
  // operand latch, repeated subtract-10 division and display commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      committed <= '0;
      rem <= '0;
      q <= '0;
      disp_a <= '0;
      disp_b <= '0;
      tens <= '0;
      ones <= '0;
    end else begin
      if (trig) begin
        op_a <= cand[3:0];
        op_b <= cand[7:4];
        committed <= cand;
      end
      if (state == LOAD) begin
        rem <= {1'b0, op_a} + {1'b0, op_b};
        q <= '0;
      end
      if (state == DIV && rem >= 5'd10) begin
        rem <= rem - 5'd10;
        q <= q + 4'd1;
      end
      if (state == COMMIT) begin
        disp_a <= op_a;
        disp_b <= op_b;
        tens <= q;
        ones <= rem[3:0];
      end
    end
  end
  // free-running slot timer, index advance and registered digit mux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
      idx <= '0;
      dig_val <= '0;
    end else begin
      tick <= wrap ? '0 : tick + 1'b1;
      if (wrap) idx <= idx + 2'd1;
      dig_val <= idx == 2'd0 ? disp_a : idx == 2'd1 ? disp_b : idx == 2'd2 ? tens : ones;
    end
  end
  // anodes blank for the first cycle of every slot to avoid ghosting
  always_comb begin
    wrap = tick == SW'(SCAN_DIV - 1);
    dig_an = tick == '0 ? 4'hF : ~(4'b0001 << idx);
  end
  tens_range: assert property (@(posedge clk) disable iff (!rst_n) tens <= 4'd3);
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for the seven-segment sequencer
module tb_seg_scan_ctrl;
  logic clk, rst_n;
  logic [7:0] btn;
  logic [3:0] dig_val, dig_an;
  logic busy, upd;
  typedef struct {logic [3:0] a, b, t, o; int lat;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int checks = 0, failures = 0, upd_cnt = 0, run = 0;
  bit pend = 0;
  seg_scan_ctrl #(.DEB_CYCLES(4), .SCAN_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .dig_val(dig_val),
    .dig_an(dig_an), .busy(busy), .upd(upd)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask
  function automatic void push(input logic [7:0] v);
    exp_t e;
    int sum;
    e.a = ~v[3:0];
    e.b = ~v[7:4];
    sum = int'(e.a) + int'(e.b);
    e.t = 4'(sum / 10);
    e.o = 4'(sum % 10);
    e.lat = 3 + sum / 10;
    sb.push_back(e);
  endfunction
  always @(negedge clk) begin
    if (pend) begin
      chk("disp_a", dut.disp_a, cur.a);
      chk("disp_b", dut.disp_b, cur.b);
      chk("tens", dut.tens, cur.t);
      chk("ones", dut.ones, cur.o);
      pend = 0;
    end
    run = busy ? run + 1 : 0;
    if (upd) begin
      upd_cnt++;
      if (sb.size() == 0) chk("spurious_upd", 1, 0);
      else begin
        cur = sb.pop_front();
        chk("latency", run, cur.lat);
        pend = 1;
      end
    end
  end
  task automatic wait_upd(input int target);
    int n = 0;
    while (upd_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (upd_cnt < target) chk("upd_timeout", upd_cnt, target);
  endtask
  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!busy) chk("busy_timeout", 0, 1);
  endtask
  task automatic wait_an(input logic [3:0] an);
    int n = 0;
    while (dig_an != an && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (dig_an != an) chk("an_timeout", dig_an, an);
  endtask
  task automatic read_slots(input logic [3:0] ea, eb, et, eo);
    logic [3:0] e[4];
    logic [3:0] an;
    e = '{ea, eb, et, eo};
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      an = ~(4'b0001 << i);
      wait_an(an);
      chk($sformatf("dig_val_slot%0d", i), dig_val, e[i]);
    end
  endtask
  initial begin
    int base;
    logic [3:0] last, an;
    int blanks;
    rst_n = 1;
    btn = 8'hFF;
    #3 rst_n = 0;
    #2;
    chk("rst_an", dig_an, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_upd", upd, 0);
    chk("rst_val", dig_val, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("idle_no_upd", upd_cnt, 0);
    btn = 8'h88;
    push(btn);
    wait_upd(1);
    read_slots(4'd7, 4'd7, 4'd1, 4'd4);
    base = upd_cnt;
    btn = 8'hFA;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 3 == 2) btn[0] = ~btn[0];
    end
    chk("bounce_no_upd", upd_cnt, base);
    btn = 8'hFA;
    push(btn);
    wait_upd(base + 1);
    read_slots(4'd5, 4'd0, 4'd0, 4'd5);
    repeat (20) @(negedge clk);
    chk("bounce_one_upd", upd_cnt, base + 1);
    base = upd_cnt;
    btn = 8'h66;
    push(btn);
    wait_busy();
    btn = 8'hEE;
    push(btn);
    wait_upd(base + 2);
    read_slots(4'd1, 4'd1, 4'd0, 4'd2);
    base = upd_cnt;
    btn = 8'h00;
    push(btn);
    wait_busy();
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_an", dig_an, 4'hF);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_upd", upd, 0);
    @(negedge clk);
    rst_n = 1;
    chk("abort_no_upd", upd_cnt, base);
    wait_an(4'b1110);
    chk("post_rst_slot0", dig_val, 0);
    wait_upd(base + 1);
    read_slots(4'd15, 4'd15, 4'd3, 4'd0);
    wait_an(4'b1110);
    last = dig_an;
    blanks = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      an = dig_an;
      chk("an_onehot", int'(an == 4'hF || $countones(~an) == 1), 1);
      if (an == 4'hF) blanks++;
      else if (an != last) begin
        chk("an_seq", an, {last[2:0], last[3]});
        last = an;
      end
    end
    chk("slot_blanks", blanks, 4);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
